// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04-style sensor emulator: validates trig width, waits a burst delay,
// then drives an echo pulse whose width encodes the programmed distance.
module ultrasonic_echo_emulator #(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int TRIG_MIN_US   = 10,
  parameter int ECHO_DELAY_US = 500,
  parameter int US_PER_CM     = 58,
  parameter int MAX_RANGE_CM  = 400,
  parameter int TIMEOUT_US    = 38000,
  parameter int HOLDOFF_US    = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  output logic        echo,
  input  logic [15:0] distance_cm,
  input  logic        enable,
  output logic        busy,
  output logic        trig_err,
  output logic        echo_done
);

  localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;

  localparam logic [23:0] TRIG_MIN_C =
    24'(TRIG_MIN_US * CYC_PER_US);
  localparam logic [23:0] DELAY_C =
    24'(ECHO_DELAY_US * CYC_PER_US);
  localparam logic [23:0] CM_C =
    24'(US_PER_CM * CYC_PER_US);
  localparam logic [23:0] TIMEOUT_C =
    24'(TIMEOUT_US * CYC_PER_US);
  localparam logic [23:0] HOLD_C =
    24'(HOLDOFF_US * CYC_PER_US);
  localparam logic [15:0] MAX_C =
    16'(MAX_RANGE_CM);
  localparam logic [23:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    DELAY,
    ECHO,
    HOLDOFF
  } state_t;

  state_t      state_q;
  logic [23:0] cnt_q;
  logic [15:0] dist_q;
  logic [23:0] len_q;
  logic        trig_s1_q;
  logic        trig_s_q;
  logic        trig_p_q;
  logic        echo_q;
  logic        busy_q;
  logic        err_q;
  logic        done_q;

  logic        trig_rise;
  logic        width_ok;
  logic        in_range;
  logic [23:0] cnt_d;
  logic [23:0] prod;
  logic [23:0] len_d;

  assign trig_rise = trig_s_q & ~trig_p_q;

  // counter value includes the edge cycle itself
  assign width_ok =
    ({1'b0, cnt_q} + 25'd1) >= {1'b0, TRIG_MIN_C};

  assign cnt_d =
    (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 24'd1;

  assign in_range =
    (dist_q != 16'd0) && (dist_q <= MAX_C);

  assign prod  = 24'(dist_q) * CM_C;
  assign len_d = in_range ? prod : TIMEOUT_C;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dist_q    <= '0;
      len_q     <= '0;
      trig_s1_q <= 1'b0;
      trig_s_q  <= 1'b0;
      trig_p_q  <= 1'b0;
      echo_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      trig_s1_q <= trig;
      trig_s_q  <= trig_s1_q;
      trig_p_q  <= trig_s_q;
      err_q     <= 1'b0;
      done_q    <= 1'b0;

      unique case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (trig_rise && enable) begin
            state_q <= TRIG_HI;
            cnt_q   <= '0;
          end
        end

        TRIG_HI: begin
          if (trig_s_q) begin
            cnt_q <= cnt_d;
          end else if (width_ok) begin
            dist_q  <= distance_cm;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= DELAY;
          end else begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end

        DELAY: begin
          // multiply settles from the latched distance
          len_q <= len_d;
          if (cnt_q == DELAY_C - 24'd1) begin
            echo_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ECHO;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ECHO: begin
          if (cnt_q == len_q - 24'd1) begin
            echo_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= HOLDOFF;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        HOLDOFF: begin
          if (cnt_q == HOLD_C - 24'd1) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          echo_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign echo      = echo_q;
  assign busy      = busy_q;
  assign trig_err  = err_q;
  assign echo_done = done_q;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed bench for ultrasonic_echo_emulator, run at a scaled-down clock
// and shortened delays so every scenario fits a short simulation.
module tb_ultrasonic_echo_emulator;

  localparam int CLK_HZ = 2_000_000;
  localparam int CYC    = 2;
  localparam int TMIN   = 10;
  localparam int DLY    = 50;
  localparam int UPC    = 58;
  localparam int MAXR   = 40;
  localparam int TOUT   = 3000;
  localparam int HOLD   = 200;

  localparam int DLY_C  = DLY * CYC;
  localparam int HOLD_C = HOLD * CYC;
  localparam int TOUT_C = TOUT * CYC;
  localparam int CM_C   = UPC * CYC;
  localparam int TMIN_C = TMIN * CYC;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic        echo;
  logic [15:0] distance_cm;
  logic        enable;
  logic        busy;
  logic        trig_err;
  logic        echo_done;

  int n_chk  = 0;
  int n_fail = 0;
  int r, f, b, d, e;
  int act, ek;

  ultrasonic_echo_emulator #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .TRIG_MIN_US  (TMIN),
    .ECHO_DELAY_US(DLY),
    .US_PER_CM    (UPC),
    .MAX_RANGE_CM (MAXR),
    .TIMEOUT_US   (TOUT),
    .HOLDOFF_US   (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .echo       (echo),
    .distance_cm(distance_cm),
    .enable     (enable),
    .busy       (busy),
    .trig_err   (trig_err),
    .echo_done  (echo_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic trig_pulse(input int n);
    @(negedge clk);
    trig = 1'b1;
    repeat (n) @(negedge clk);
    trig = 1'b0;
  endtask

  // cycle offsets measured from the negedge where trig fell
  task automatic meas(output int rise,
                      output int fall,
                      output int bfall,
                      output int dones,
                      output int errs);
    rise  = -1;
    fall  = -1;
    bfall = -1;
    dones = 0;
    errs  = 0;
    for (int k = 1; k <= 20000; k++) begin
      @(negedge clk);
      if (trig_err) errs++;
      if (echo_done) dones++;
      if (echo && rise < 0) rise = k;
      if (rise >= 0 && fall < 0 && !echo)
        fall = k;
      if (fall >= 0 && !busy) begin
        bfall = k;
        break;
      end
    end
  endtask

  task automatic watch(input int n,
                       output int actv,
                       output int errs,
                       output int errk,
                       output int dones);
    actv  = 0;
    errs  = 0;
    errk  = -1;
    dones = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (echo || busy) actv++;
      if (echo_done) dones++;
      if (trig_err) begin
        errs++;
        if (errk < 0) errk = k;
      end
    end
  endtask

  task automatic chk_meas(input string tag,
                          input int rise,
                          input int fall,
                          input int bfall,
                          input int dones,
                          input int errs,
                          input int exp_len);
    chk({tag, "_rise"},
        int'(rise >= DLY_C && rise <= DLY_C + 3), 1);
    chk({tag, "_width"},
        (rise < 0 || fall < 0) ? -1 : fall - rise,
        exp_len);
    chk({tag, "_done"}, dones, 1);
    chk({tag, "_hold"},
        (bfall < 0) ? -1 : bfall - fall, HOLD_C);
    chk({tag, "_err"}, errs, 0);
  endtask

  task automatic run_meas(input string tag,
                          input int hi,
                          input int exp_len);
    int rr, ff, bb, dd, ee;
    trig_pulse(hi);
    meas(rr, ff, bb, dd, ee);
    chk_meas(tag, rr, ff, bb, dd, ee, exp_len);
  endtask

  initial begin
    rst         = 1'b1;
    trig        = 1'b0;
    enable      = 1'b1;
    distance_cm = 16'd10;
    repeat (3) @(negedge clk);
    chk("rst_echo", int'(echo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(trig_err), 0);
    chk("rst_done", int'(echo_done), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // basic 10 cm, minimum-width trigger
    run_meas("d10", TMIN_C, 10 * CM_C);
    chk("d10_idle", int'(busy), 0);

    // one cycle short of the minimum width
    trig_pulse(TMIN_C - 1);
    watch(DLY_C + 50, act, e, ek, d);
    chk("short_err", e, 1);
    chk("short_errk", ek, 3);
    chk("short_act", act, 0);
    chk("short_done", d, 0);

    distance_cm = 16'd0;
    run_meas("d0", 30, TOUT_C);
    distance_cm = 16'(MAXR + 1);
    run_meas("dover", 30, TOUT_C);
    distance_cm = 16'(MAXR);
    run_meas("dmax", 30, MAXR * CM_C);

    // distance change and second trig during a measurement
    distance_cm = 16'd25;
    trig_pulse(30);
    fork
      meas(r, f, b, d, e);
      begin
        repeat (10) @(negedge clk);
        distance_cm = 16'd5;
        repeat (DLY_C + 50) @(negedge clk);
        trig = 1'b1;
        repeat (30) @(negedge clk);
        trig = 1'b0;
      end
    join
    chk_meas("latch", r, f, b, d, e, 25 * CM_C);
    watch(100, act, e, ek, d);
    chk("latch_after", act, 0);

    // disabled trigger, then enable with trig already high
    distance_cm = 16'd10;
    enable = 1'b0;
    trig_pulse(30);
    watch(DLY_C + 50, act, e, ek, d);
    chk("dis_act", act, 0);
    @(negedge clk);
    trig = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (30) @(negedge clk);
    trig = 1'b0;
    watch(DLY_C + 50, act, e, ek, d);
    chk("en_hi_act", act, 0);
    chk("en_hi_err", e, 0);
    run_meas("en_ok", 30, 10 * CM_C);

    // reset in the middle of the echo
    distance_cm = 16'd20;
    trig_pulse(30);
    for (int k = 0; k < 1000 && !echo; k++)
      @(negedge clk);
    chk("rm_rise", int'(echo), 1);
    repeat (1000) @(negedge clk);
    chk("rm_pre", int'(echo), 1);
    rst = 1'b1;
    #1;
    chk("rm_echo", int'(echo), 0);
    chk("rm_busy", int'(busy), 0);
    watch(5, act, e, ek, d);
    chk("rm_done", d, 0);
    chk("rm_act", act, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_meas("rm_ok", 30, 20 * CM_C);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ultrasonic_echo_emulator.md
Name: ultrasonic_echo_emulator

Overview:
Emulates the sensor side of the HC-SR04-style trigger/echo interface for hardware-in-the-loop and bench use. It watches the trig line driven by the ranging logic, validates the trigger pulse width, and waits a fixed burst delay. It then drives an echo pulse whose width encodes a programmed distance at 58 us per cm. It sits on the board pins in place of the physical sensor; the ranging block and the servo path run unchanged.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency; CYC_PER_US = CLK_FREQ_HZ/1_000_000, fixed at elaboration.
TRIG_MIN_US, 10, minimum valid trig high time in us.
ECHO_DELAY_US, 500, time from trig falling edge detection to echo rise, in us.
US_PER_CM, 58, echo high time per cm, in us.
MAX_RANGE_CM, 400, largest distance reported as an in-range echo.
TIMEOUT_US, 38000, echo width for an out-of-range or zero distance.
HOLDOFF_US, 10000, dead time after echo falls; trig is ignored during this time.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
trig  input  1  trigger from the ranging logic; asynchronous to clk
echo  output  1  emulated echo pulse
distance_cm  input  16  programmed target distance; sampled once per valid trigger
enable  input  1  when 0, triggers are ignored and no new measurement starts
busy  output  1  high from valid trigger acceptance until holdoff ends
trig_err  output  1  one-cycle pulse when a trig pulse shorter than TRIG_MIN_US ends
echo_done  output  1  one-cycle pulse on the cycle echo falls

Behaviour:
- Reset (async, rst=1): echo=0, busy=0, trig_err=0, echo_done=0, FSM=IDLE, all counters=0, synchronizer flops=0.
- trig passes through a 2-flop synchronizer; all edge and width decisions use the synchronized value trig_s. Total latency is 2 clk.
- Counters are 24 bits, which covers TIMEOUT_US*CYC_PER_US = 3_800_000 at defaults. Counter increments saturate and never wrap.
- FSM states: IDLE, TRIG_HI, DELAY, ECHO, HOLDOFF.
- IDLE
  - Rising edge of trig_s with enable=1: go to TRIG_HI and clear the width counter.
  - Rising edge with enable=0: stay in IDLE.
  - busy=0 in this state.
- TRIG_HI
  - Count clocks while trig_s=1.
  - On trig_s falling, width >= TRIG_MIN_US*CYC_PER_US: the trigger is valid.
    - Latch distance_cm into dist_q.
    - Compute echo_len:
      - dist_q==0 or dist_q>MAX_RANGE_CM: TIMEOUT_US*CYC_PER_US.
      - Otherwise: dist_q*US_PER_CM*CYC_PER_US, as one registered multiply.
    - Go to DELAY and set busy=1.
  - On trig_s falling, width below the minimum: pulse trig_err for 1 cycle and return to IDLE.
  - A trig held high indefinitely only saturates the counter; the trigger is evaluated at its fall.
- DELAY
  - Count ECHO_DELAY_US*CYC_PER_US cycles, then go to ECHO.
  - echo goes to 1 on the first ECHO cycle.
- ECHO
  - echo=1 for exactly echo_len cycles.
  - On the cycle echo returns to 0, echo_done=1 for that cycle, and the FSM goes to HOLDOFF.
- HOLDOFF
  - Count HOLDOFF_US*CYC_PER_US cycles, then go to IDLE and set busy=0.
- Trig activity in DELAY, ECHO or HOLDOFF is ignored. A trig still high when IDLE is re-entered does not start a measurement; a fresh rising edge is required.
- enable going to 0 mid-measurement does not abort it. The measurement completes, and enable is only checked in IDLE.
- distance_cm changes after the latch point do not affect the echo in progress.
- rst asserted mid-measurement: echo drops immediately (asynchronously) and no echo_done is issued.
- echo is driven from a flop with no combinational path from any input.

Test Plan:
- Reset, enable=1, distance_cm=10, trig high 1000 clk -> trig_err=0; echo rises 50_000 clk (±3) after trig falls; echo high exactly 58_000 clk; echo_done pulses once; busy falls 1_000_000 clk after echo falls.
- trig high 999 clk -> trig_err single pulse about 3 clk after trig falls; echo stays 0; busy stays 0.
- distance_cm=0, then distance_cm=401, each with a valid trig -> echo width 3_800_000 clk. Separately, distance_cm=400 -> echo width 2_320_000 clk.
- Valid trig with distance_cm=25, then change distance_cm to 5 during DELAY, and issue a second trig during ECHO -> single echo of 145_000 clk; the second trig is ignored; exactly one echo_done.
- enable=0 with a valid trig -> no busy, no echo. Set enable=1 while trig is already high, then trig falls -> no measurement. Next full trig -> normal echo.
- rst asserted 1000 clk into ECHO -> echo=0 the same cycle; busy=0; no echo_done. After release, a valid trig produces a normal echo.
